// File: rtl/dac_ctrl_pkg.sv
// rtl/dac_ctrl_pkg.sv - shared types, init ROM and frame helper for the PCM1780 control port
package dac_ctrl_pkg;
    localparam int FRAME_W  = 16;
    localparam int INIT_LEN = 3;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } dac_wr_t;

    typedef enum logic [2:0] {
        ST_INIT_ARB,
        ST_IDLE,
        ST_WAIT_TICK,
        ST_SHIFT,
        ST_GAP
    } dac_state_e;

    // Power-up writes: attenuation L/R to 0 dB, then unmute.
    function automatic dac_wr_t init_rom(input logic [1:0] idx);
        dac_wr_t wr;
        case (idx)
            2'd0:    wr = '{addr: 7'd16, data: 8'hFF};
            2'd1:    wr = '{addr: 7'd17, data: 8'hFF};
            default: wr = '{addr: 7'd18, data: 8'h00};
        endcase
        return wr;
    endfunction

    function automatic logic [FRAME_W-1:0] make_frame(input dac_wr_t wr);
        return {1'b0, wr.addr, wr.data};
    endfunction
endpackage

// File: rtl/dac_ctrl_ser.sv
// rtl/dac_ctrl_ser.sv - MC divider and 16-bit MS/MD shifter with load/busy handshake
module dac_ctrl_ser
    import dac_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               tick_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               sel_n_o,
    output logic               clock_o,
    output logic               data_o
);
    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0]   div_q, div_d;
    logic               clock_q;
    logic               pending_q, active_q;
    logic [3:0]         cnt_q;
    logic [FRAME_W-1:0] shift_q;
    logic               sel_n_q, data_q;

    // tick_o marks the cycle whose closing edge is the MC falling edge
    assign tick_o  = (div_q == DIV_LAST);
    assign div_d   = tick_o ? '0 : div_q + 1'b1;
    assign busy_o  = pending_q | active_q;
    assign done_o  = tick_o & active_q & (cnt_q == 4'd0);
    assign sel_n_o = sel_n_q;
    assign clock_o = clock_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q     <= '0;
            clock_q   <= 1'b0;
            pending_q <= 1'b0;
            active_q  <= 1'b0;
            cnt_q     <= 4'd0;
            shift_q   <= '0;
            sel_n_q   <= 1'b1;
            data_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            clock_q <= (div_d >= DIV_HALF);
            if (load_i && !busy_o) begin
                shift_q   <= frame_i;
                pending_q <= 1'b1;
            end else if (tick_o) begin
                if (pending_q) begin
                    sel_n_q   <= 1'b0;
                    data_q    <= shift_q[FRAME_W-1];
                    shift_q   <= shift_q << 1;
                    cnt_q     <= 4'd15;
                    pending_q <= 1'b0;
                    active_q  <= 1'b1;
                end else if (active_q) begin
                    if (cnt_q != 4'd0) begin
                        data_q  <= shift_q[FRAME_W-1];
                        shift_q <= shift_q << 1;
                        cnt_q   <= cnt_q - 4'd1;
                    end else begin
                        sel_n_q  <= 1'b1;
                        data_q   <= 1'b0;
                        active_q <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/dac_ctrl_arbiter.sv
// rtl/dac_ctrl_arbiter.sv - init sequencer and round-robin arbiter for the PCM1780 control port
module dac_ctrl_arbiter
    import dac_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int CLK_DIV  = 8,
    parameter int GAP_BITS = 2,
    parameter bit INIT_EN  = 1'b1
) (
    input  logic                 i_clk48,
    input  logic                 i_rst48_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [7*NUM_REQ-1:0] i_req_addr,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic                 o_init_done,
    output logic                 o_busy,
    output logic                 o_sel_n,
    output logic                 o_clock,
    output logic                 o_data
);
    localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int               GAP_W     = $clog2(GAP_BITS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_BITS - 1);
    localparam logic [1:0]       INIT_LAST = 2'(INIT_LEN - 1);
    localparam dac_state_e       RESET_ST  = INIT_EN ? ST_INIT_ARB : ST_IDLE;

    dac_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [1:0]         idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               init_done_q, init_done_d;

    logic [PTR_W-1:0]   winner, cand;
    logic               grant, load;
    logic [FRAME_W-1:0] frame;
    logic               tick, ser_busy, ser_done;
    dac_wr_t            req_wr;

    // Scan downward so the candidate closest to ptr_q is the one that sticks
    always_comb begin
        winner = ptr_q;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (i_req_valid[cand]) winner = cand;
        end
    end

    assign grant       = (state_q == ST_IDLE) && init_done_q && (|i_req_valid);
    assign req_wr.addr = i_req_addr[7*int'(winner) +: 7];
    assign req_wr.data = i_req_data[8*int'(winner) +: 8];

    always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
        if (!i_rst48_n) begin
            state_q     <= RESET_ST;
            ptr_q       <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        init_done_d = init_done_q | ~INIT_EN;
        case (state_q)
            ST_INIT_ARB: state_d = ST_WAIT_TICK;
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_WAIT_TICK;
                    ptr_d   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            ST_WAIT_TICK: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: begin
                gap_d = '0;
                if (ser_done) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tick) begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GAP_LAST) begin
                        if (init_done_q) begin
                            state_d = ST_IDLE;
                        end else if (idx_q == INIT_LAST) begin
                            state_d     = ST_IDLE;
                            init_done_d = 1'b1;
                        end else begin
                            state_d = ST_INIT_ARB;
                            idx_d   = idx_q + 2'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        load        = 1'b0;
        frame       = make_frame(req_wr);
        case (state_q)
            ST_INIT_ARB: begin
                load  = 1'b1;
                frame = make_frame(init_rom(idx_q));
            end
            ST_IDLE: begin
                if (grant) begin
                    load                = 1'b1;
                    o_req_ready[winner] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset state is INIT_ARB, so busy is masked while reset is held
    assign o_busy      = i_rst48_n && (state_q != ST_IDLE);
    assign o_init_done = init_done_q;

    dac_ctrl_ser #(
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .clk_i   (i_clk48),
        .rst_n_i (i_rst48_n),
        .load_i  (load),
        .frame_i (frame),
        .tick_o  (tick),
        .busy_o  (ser_busy),
        .done_o  (ser_done),
        .sel_n_o (o_sel_n),
        .clock_o (o_clock),
        .data_o  (o_data)
    );

    logic unused_ser_busy;
    assign unused_ser_busy = ser_busy;
endmodule

// File: tb/tb_dac_ctrl_arbiter.sv
// tb/tb_dac_ctrl_arbiter.sv - scoreboard bench for dac_ctrl_arbiter
module tb_dac_ctrl_arbiter;
    localparam int NUM_REQ  = 3;
    localparam int CLK_DIV  = 8;
    localparam int GAP_BITS = 2;
    localparam int LOW_CYC  = 16 * CLK_DIV;
    localparam int MIN_HIGH = GAP_BITS * CLK_DIV;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic                 init_done, busy, sel_n, mc, md;

    dac_ctrl_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .CLK_DIV  (CLK_DIV),
        .GAP_BITS (GAP_BITS),
        .INIT_EN  (1'b1)
    ) dut (
        .i_clk48     (clk),
        .i_rst48_n   (rst_n),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_init_done (init_done),
        .o_busy      (busy),
        .o_sel_n     (sel_n),
        .o_clock     (mc),
        .o_data      (md)
    );

    always #10 clk = ~clk;

    int                 n_cmp = 0;
    int                 n_fail = 0;
    logic [15:0]        exp_q[$];
    logic [NUM_REQ-1:0] pend = '0;
    logic [NUM_REQ-1:0] acc_flag = '0;
    logic [6:0]         m_addr[NUM_REQ];
    logic [7:0]         m_data[NUM_REQ];
    int                 model_ptr = 0;

    logic        p_clk, p_sel, p_data, had_frame;
    int          low_cnt, high_cnt, bits, frames_done, mw;
    logic [15:0] shreg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic push_init();
        exp_q.push_back(16'h10FF);
        exp_q.push_back(16'h11FF);
        exp_q.push_back(16'h1200);
    endtask

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[7*i +: 7] = m_addr[i];
            req_data[8*i +: 8] = m_data[i];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (acc_flag[i]) begin
                pend[i]     = 1'b0;
                acc_flag[i] = 1'b0;
            end
        drive();
    endtask

    task automatic raise(input int i, input logic [6:0] a, input logic [7:0] d);
        m_addr[i] = a;
        m_data[i] = d;
        pend[i]   = 1'b1;
        drive();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while ((pend != 0 || exp_q.size() != 0 || !sel_n) && t < budget) begin
            cyc();
            t++;
        end
        chk(name, 32'(t < budget), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel_n"}, sel_n, 1);
        chk({tag, "_mc"}, mc, 0);
        chk({tag, "_md"}, md, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_init_done"}, init_done, 0);
    endtask

    // Bus monitor and ready scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            p_clk = 1'b0; p_sel = 1'b1; p_data = 1'b0;
            bits = 0; low_cnt = 0; high_cnt = 0; frames_done = 0;
            had_frame = 1'b0; shreg = '0;
        end else begin
            if (md !== p_data)  chk("md_change_on_mc_fall", {p_clk, mc}, 2'b10);
            if (sel_n !== p_sel) chk("ms_change_on_mc_fall", {p_clk, mc}, 2'b10);
            if (p_sel && !sel_n) begin
                bits = 0; low_cnt = 0; shreg = '0;
                chk("busy_in_frame", busy, 1);
                if (had_frame) chk("ms_high_min", 32'(high_cnt >= MIN_HIGH), 1);
            end
            if (!p_sel && sel_n) begin
                chk("frame_bits", bits, 16);
                chk("ms_low_cycles", low_cnt, LOW_CYC);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got 0x%h, no frame expected", shreg);
                end else begin
                    chk("frame_value", shreg, exp_q.pop_front());
                end
                if (frames_done < 3) chk("init_done_low_during_init", init_done, 0);
                frames_done++;
                had_frame = 1'b1;
                high_cnt = 0;
            end
            if (!sel_n) begin
                low_cnt++;
                if (!p_clk && mc) begin
                    shreg = {shreg[14:0], md};
                    bits++;
                end
            end else begin
                high_cnt++;
            end
            if (sel_n && had_frame && frames_done >= 3 && high_cnt == MIN_HIGH + 1 && req_valid != 0)
                chk("grant_first_idle_after_gap", 32'(req_ready != 0), 1);
            if (req_ready != 0) begin
                mw = rr_pick(req_valid, model_ptr);
                chk("ready_while_ms_low", sel_n, 1);
                chk("ready_before_init", 32'(frames_done >= 3), 1);
                if (had_frame) chk("ready_during_gap", 32'(high_cnt > MIN_HIGH), 1);
                chk("ready_grant", req_ready, (mw < 0) ? 0 : (1 << mw));
                if (mw >= 0) begin
                    exp_q.push_back({1'b0, m_addr[mw], m_data[mw]});
                    model_ptr = (mw + 1) % NUM_REQ;
                    acc_flag[mw] = 1'b1;
                end
            end
            p_clk = mc; p_sel = sel_n; p_data = md;
        end
    end

    initial begin
        int t;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        push_init();
        rst_n = 1'b1;

        raise(0, 7'h10, 8'h80);
        wait_drain("drain_init_and_req0", 3000);
        chk("init_done_after_init", init_done, 1);

        for (int i = 0; i < NUM_REQ; i++) raise(i, 7'($urandom), 8'($urandom));
        wait_drain("drain_all_three", 2000);
        raise(1, 7'h21, 8'h5A);
        wait_drain("drain_req1_alone", 1000);

        raise(0, 7'h13, 8'hC3);
        t = 0;
        while (sel_n && t < 200) begin cyc(); t++; end
        chk("frame_started", sel_n, 0);
        repeat (40) cyc();
        raise(2, 7'h44, 8'h3C);
        wait_drain("drain_req2_mid_frame", 1000);

        for (int c = 0; c < 3000; c++) begin
            cyc();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 39) == 0) begin
                    raise(i, 7'($urandom), 8'($urandom));
                end else if (pend[i] && $urandom_range(0, 299) == 0) begin
                    pend[i] = 1'b0;
                    drive();
                end
            end
        end
        wait_drain("drain_random", 3000);

        for (int i = 0; i < NUM_REQ; i++) raise(i, 7'($urandom), 8'($urandom));
        t = 0;
        while (!(!sel_n && bits == 7) && t < 400) begin cyc(); t++; end
        chk("reached_bit7", bits, 7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        pend = '0;
        acc_flag = '0;
        model_ptr = 0;
        drive();
        push_init();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) raise(i, 7'($urandom), 8'($urandom));
        wait_drain("drain_after_reset", 4000);
        chk("init_done_after_replay", init_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
